ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the same two open-collector lines the keyboard receiver listens on. It sits beside the keyboard receiver inside the CPU in the CLK_CPU domain. It drives the clock and data lines only through pull-low enables; the top level converts each enable to a pin value of 0 or Z. While a transfer is in progress it raises `busy`, and the keyboard receiver discards the edges it sees during that time.

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts out one byte plus parity and stop, then checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 60,
    parameter int unsigned TIMEOUT_CYCLES = 7500
) (
    input  logic       CLK_CPU,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    output logic       keyboard_clock_oe,
    output logic       keyboard_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    state_t      state_q;
    logic [IW-1:0] inh_q;
    logic [CW-1:0] to_q;
    logic [3:0]  n_q;
    logic [9:0]  frame_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        coe_q;
    logic        doe_q;

    logic        kclk_s1_q;
    logic        kclk_s2_q;
    logic        kclk_prev_q;
    logic        kdat_s1_q;
    logic        kdat_s2_q;
    logic        fe;
    logic        timed;

    // Synchronizers reset to the idle (released) line level so no edge is seen at reset.
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_s1_q   <= 1'b1;
            kdat_s2_q   <= 1'b1;
        end else begin
            kclk_s1_q   <= keyboard_clock;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdat_s1_q   <= keyboard_data;
            kdat_s2_q   <= kdat_s1_q;
        end
    end

    assign fe    = kclk_prev_q & ~kclk_s2_q;
    assign timed = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                   (state_q == S_ACK);

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            inh_q   <= '0;
            to_q    <= '0;
            n_q     <= '0;
            frame_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            coe_q   <= 1'b0;
            doe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (tx_valid) begin
                        frame_q <= {1'b1, ~^tx_data, tx_data};
                        inh_q   <= '0;
                        coe_q   <= 1'b1;
                        doe_q   <= (INHIBIT_CYCLES == 1);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    inh_q <= inh_q + 1'b1;
                    if (32'(inh_q) + 32'd2 == INHIBIT_CYCLES) begin
                        doe_q <= 1'b1;
                    end
                    if (32'(inh_q) + 32'd1 >= INHIBIT_CYCLES) begin
                        coe_q   <= 1'b0;
                        to_q    <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    n_q     <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (fe) begin
                        doe_q   <= ~frame_q[0];
                        frame_q <= frame_q >> 1;
                        n_q     <= n_q + 1'b1;
                        if (n_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (fe) begin
                        if (kdat_s2_q) begin
                            err_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kclk_s2_q && kdat_s2_q) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Watchdog on device clocking; a hit aborts and overrides the case above.
            if (timed) begin
                if (fe) begin
                    to_q <= '0;
                end else if (to_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_q   <= 1'b1;
                    coe_q   <= 1'b0;
                    doe_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end
        end
    end

    assign tx_ready          = ready_q;
    assign tx_done           = done_q;
    assign tx_error          = err_q;
    assign busy              = busy_q;
    assign keyboard_clock_oe = coe_q;
    assign keyboard_data_oe  = doe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector line model
// and a simple PS/2 device that clocks the frame in and ACKs or NACKs.
module tb_ps2_host_tx;

    logic       CLK_CPU = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       keyboard_clock;
    logic       keyboard_data;
    logic       keyboard_clock_oe;
    logic       keyboard_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int npass = 0;
    int ntot  = 0;
    int ndone = 0;
    int nerr  = 0;

    assign keyboard_clock = dev_clk & ~keyboard_clock_oe;
    assign keyboard_data  = dev_dat & ~keyboard_data_oe;

    ps2_host_tx dut (
        .CLK_CPU          (CLK_CPU),
        .resetn           (resetn),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_done          (tx_done),
        .tx_error         (tx_error),
        .busy             (busy),
        .keyboard_clock   (keyboard_clock),
        .keyboard_data    (keyboard_data),
        .keyboard_clock_oe(keyboard_clock_oe),
        .keyboard_data_oe (keyboard_data_oe)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    always @(negedge CLK_CPU) begin
        if (tx_done) ndone++;
        if (tx_error) nerr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start(input logic [7:0] b, output int inh,
                         output logic last_doe);
        inh = 0;
        last_doe = 1'b0;
        @(negedge CLK_CPU);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLK_CPU);
        tx_valid = 1'b0;
        while (keyboard_clock_oe === 1'b1 && inh < 1000) begin
            last_doe = keyboard_data_oe;
            inh++;
            @(negedge CLK_CPU);
        end
    endtask

    task automatic xfer(input string nm, input logic [7:0] b,
                        input bit ack, input bit inject,
                        input logic [9:0] exp_bits);
        int d0;
        int e0;
        int inh;
        int w;
        logic last_doe;
        logic [9:0] bits;
        d0 = ndone;
        e0 = nerr;
        bits = '0;
        start(b, inh, last_doe);
        check({nm, ":inhibit"}, inh, 60);
        check({nm, ":start_last"}, {31'd0, last_doe}, 1);
        repeat (10) @(negedge CLK_CPU);
        check({nm, ":start_req"}, {31'd0, keyboard_data_oe}, 1);
        check({nm, ":busy"}, {31'd0, busy}, 1);
        if (inject) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            repeat (2) @(negedge CLK_CPU);
            tx_valid = 1'b0;
        end
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge CLK_CPU);
            if (i == 10) begin
                check({nm, ":wait_idle"}, {31'd0, tx_ready}, 0);
            end
            dev_clk = 1'b1;
            if (i < 10) bits[i] = keyboard_data;
            repeat (5) @(negedge CLK_CPU);
            if (i == 9) dev_dat = ~ack;
            repeat (15) @(negedge CLK_CPU);
        end
        dev_dat = 1'b1;
        w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin
            w++;
            @(negedge CLK_CPU);
        end
        @(negedge CLK_CPU);
        check({nm, ":ready"}, {31'd0, tx_ready}, 1);
        check({nm, ":bits"}, {22'd0, bits}, {22'd0, exp_bits});
        check({nm, ":done"}, ndone - d0, ack ? 1 : 0);
        check({nm, ":err"}, nerr - e0, ack ? 0 : 1);
        check({nm, ":idle"}, {30'd0, busy, keyboard_data_oe}, 0);
    endtask

    initial begin
        int k;
        int inh;
        int e0;
        int d0;
        logic last_doe;

        repeat (3) @(negedge CLK_CPU);
        check("rst_ready", {31'd0, tx_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pulses", {30'd0, tx_done, tx_error}, 0);
        check("rst_oe", {30'd0, keyboard_clock_oe, keyboard_data_oe}, 0);
        resetn = 1'b1;
        repeat (3) @(negedge CLK_CPU);

        xfer("ed", 8'hED, 1'b1, 1'b0, 10'b1111101101);
        xfer("01", 8'h01, 1'b1, 1'b0, 10'b1000000001);
        xfer("ff", 8'hFF, 1'b1, 1'b0, 10'b1111111111);
        xfer("nack", 8'hED, 1'b0, 1'b0, 10'b1111101101);

        // Silent device: the watchdog must fire 7500 cycles into REQ.
        e0 = nerr;
        d0 = ndone;
        start(8'hA5, inh, last_doe);
        check("to_inhibit", inh, 60);
        k = 0;
        while (tx_error !== 1'b1 && k < 8000) begin
            @(negedge CLK_CPU);
            k++;
        end
        check("to_cycles", k, 7500);
        check("to_oe", {30'd0, keyboard_clock_oe, keyboard_data_oe}, 0);
        @(negedge CLK_CPU);
        check("to_ready", {31'd0, tx_ready}, 1);
        check("to_err", nerr - e0, 1);
        check("to_done", ndone - d0, 0);

        // Reset while a zero data bit is being driven.
        start(8'h00, inh, last_doe);
        repeat (10) @(negedge CLK_CPU);
        dev_clk = 1'b0;
        repeat (20) @(negedge CLK_CPU);
        dev_clk = 1'b1;
        repeat (10) @(negedge CLK_CPU);
        check("rm_pre", {31'd0, keyboard_data_oe}, 1);
        resetn = 1'b0;
        #1;
        check("rm_oe", {30'd0, keyboard_clock_oe, keyboard_data_oe}, 0);
        repeat (3) @(negedge CLK_CPU);
        resetn = 1'b1;
        @(negedge CLK_CPU);
        check("rm_idle", {30'd0, tx_ready, busy}, 2);
        xfer("rm_ed", 8'hED, 1'b1, 1'b0, 10'b1111101101);

        xfer("inj", 8'h3C, 1'b1, 1'b1, 10'b1100111100);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
